// File: rtl/link_pkg.sv
// link_pkg: shared state encoding and constants for the Game Boy link peer.
package link_pkg;
    typedef enum logic [2:0] {IDLE, F_SHIFT, M_LOW, M_HIGH, DONE} link_state_t;
    localparam logic [7:0] LINK_IDLE_BYTE = 8'hFF;
    localparam int LINK_BITS = 8;
endpackage

// File: rtl/link_peer_shifter.sv
// link_peer_shifter: paired tx/rx byte shifters with bit counter and byte-complete flag.
module link_peer_shifter
    import link_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_data,
    input  logic       i_shift,
    input  logic       i_rx_bit,
    output logic       o_tx_bit,
    output logic [7:0] o_rx_data,
    output logic       o_done
);
    logic [7:0] r_tx_sr;
    logic [7:0] r_rx_sr;
    logic [3:0] r_bit_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_sr   <= LINK_IDLE_BYTE;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_tx_sr   <= i_load_data;
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            r_tx_sr   <= {r_tx_sr[6:0], 1'b1};
            r_rx_sr   <= {r_rx_sr[6:0], i_rx_bit};
            r_bit_cnt <= r_bit_cnt + 4'd1;
        end
    end
    assign o_tx_bit  = r_tx_sr[7];
    assign o_rx_data = r_rx_sr;
    // true on the shift that moves the last bit, so the FSM can leave without an extra cycle
    assign o_done    = i_shift && r_bit_cnt == 4'(LINK_BITS - 1);
endmodule

// File: rtl/link_peer.sv
// link_peer: Game Boy serial-link byte endpoint, follower or clock master, with host valid/ready ports.
// Define LINK_PEER_SYNC_EN to pass gb_clk_in/gb_data_in through 2-flop synchronizers.
module link_peer
    import link_pkg::*;
#(
    parameter int CLK_DIV = 511,
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_gb_clk_in,
    input  logic       i_gb_data_in,
    output logic       o_gb_clk_out,
    output logic       o_gb_data_out,
    input  logic       i_master_en,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_busy,
    output logic       o_overrun,
    output logic       o_timeout
);
    localparam int DIV_W  = CLK_DIV > 0 ? $clog2(CLK_DIV + 1) : 1;
    localparam int IDLE_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    link_state_t r_state, w_next;
    logic w_clk_in, w_data_in, r_prev_clk;
`ifdef LINK_PEER_SYNC_EN
    logic [1:0] r_clk_sync, r_data_sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_gb_clk_in};
            r_data_sync <= {r_data_sync[0], i_gb_data_in};
        end
    end
    assign w_clk_in  = r_clk_sync[1];
    assign w_data_in = r_data_sync[1];
`else
    assign w_clk_in  = i_gb_clk_in;
    assign w_data_in = i_gb_data_in;
`endif

    logic              r_hold_full;
    logic [7:0]        r_hold;
    logic [DIV_W-1:0]  r_div;
    logic [IDLE_W-1:0] r_idle;
    logic              r_rx_valid;
    logic [7:0]        r_rx_data;
    logic              r_overrun, r_timeout;
    logic              w_fall, w_rise, w_start, w_div_end, w_stall, w_shift, w_done, w_load, w_drop;
    logic [7:0]        w_rx_sr;

    assign w_fall    = r_prev_clk && !w_clk_in;
    assign w_rise    = !r_prev_clk && w_clk_in;
    assign w_div_end = r_div == DIV_W'(CLK_DIV);
    assign w_stall   = r_state == F_SHIFT && !w_fall && !w_rise && r_idle == IDLE_W'(TIMEOUT - 1);
    assign w_start   = r_state == IDLE && (i_master_en ? r_hold_full : w_fall);
    assign w_shift   = (r_state == F_SHIFT && w_rise) || (r_state == M_HIGH && w_div_end);
    // preloading while idle keeps the first bit on the line before the Game Boy clocks it
    assign w_load    = r_state == IDLE || r_state == DONE;
    assign w_drop    = r_state == DONE && r_rx_valid && !i_rx_ready;

    link_peer_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_data(r_hold_full ? r_hold : LINK_IDLE_BYTE),
        .i_shift    (w_shift),
        .i_rx_bit   (w_data_in),
        .o_tx_bit   (o_gb_data_out),
        .o_rx_data  (w_rx_sr),
        .o_done     (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? (i_master_en ? M_LOW : F_SHIFT) : IDLE;
            F_SHIFT: w_next = w_stall ? IDLE : w_done ? DONE : F_SHIFT;
            M_LOW:   w_next = w_div_end ? M_HIGH : M_LOW;
            M_HIGH:  w_next = w_done ? DONE : w_div_end ? M_LOW : M_HIGH;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_gb_clk_out = r_state != M_LOW;
        o_busy       = r_state != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_clk  <= 1'b1;
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_div       <= '0;
            r_idle      <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_prev_clk <= w_clk_in;
            if (i_tx_valid && !r_hold_full) begin
                r_hold      <= i_tx_data;
                r_hold_full <= 1'b1;
            end else if (w_start && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
            r_div      <= (r_state inside {M_LOW, M_HIGH}) && !w_div_end ? r_div + DIV_W'(1) : '0;
            r_idle     <= r_state == F_SHIFT && !w_fall && !w_rise ?
                          r_idle + IDLE_W'(r_idle != IDLE_W'(TIMEOUT)) : '0;
            r_rx_valid <= (r_state == DONE && !w_drop) || (r_rx_valid && !i_rx_ready);
            if (r_state == DONE && !w_drop) r_rx_data <= w_rx_sr;
            r_overrun  <= w_drop;
            r_timeout  <= w_stall;
        end
    end

    assign o_tx_ready = !r_hold_full;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;
    assign o_overrun  = r_overrun;
    assign o_timeout  = r_timeout;
endmodule
